// File: rtl/bit_seq_pkg.sv
// bit_seq_pkg: shared types and constants for the single-bit serial link
package bit_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} tx_state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam logic IDLE_BIT = 1'b0;
endpackage

// File: rtl/bit_seq_tx_if.sv
// bit_seq_tx_if: parallel word handshake in, serial bit stream out
interface bit_seq_tx_if import bit_seq_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] din;
  logic din_valid, din_ready, x, x_valid, busy, done;
  modport master(output din, din_valid, input din_ready, x, x_valid, busy, done);
  modport slave(input din, din_valid, output din_ready, x, x_valid, busy, done);
endinterface

// File: rtl/bit_seq_shreg.sv
// bit_seq_shreg: loadable shift register that drains toward its output end
module bit_seq_shreg import bit_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_out
);
  logic [WIDTH-1:0] q;
  // Idle bits fill in behind the data, so the output settles to idle once the word is out
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= MSB_FIRST ? {q[WIDTH-2:0], IDLE_BIT} : {IDLE_BIT, q[WIDTH-1:1]};
  assign q_out = MSB_FIRST ? q[WIDTH-1] : q[0];
endmodule

// File: rtl/bit_seq_tx.sv
// bit_seq_tx: serial transmitter with a programmable idle gap between words
module bit_seq_tx import bit_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic        clk,
  input logic        reset,
  bit_seq_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic load, shift, x_valid, busy, done, din_ready;
  bit_seq_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
    .clk(clk), .reset(reset), .load(load), .shift(shift), .d(bus.din), .q_out(bus.x)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    gcnt_n = gcnt;
    load = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE: if (bus.din_valid && din_ready) begin
        state_n = SHIFT;
        load = 1'b1;
        cnt_n = '0;
      end
      SHIFT: begin
        shift = 1'b1;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          cnt_n = '0;
          gcnt_n = '0;
          state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        gcnt_n = gcnt + 1'b1;
        if (gcnt == GW'(GAP_CYCLES - 1)) begin
          gcnt_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // Status outputs are registered from the next state so they line up with the bit on x
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      gcnt <= '0;
      x_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gcnt <= gcnt_n;
      x_valid <= state_n == SHIFT;
      busy <= state_n != IDLE;
      done <= state == SHIFT && cnt == CW'(WIDTH - 2);
      din_ready <= state_n == IDLE;
    end
  assign bus.x_valid = x_valid;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.din_ready = din_ready;
endmodule

// File: tb/tb_bit_seq_tx.sv
// tb_bit_seq_tx: directed checks of bit order, gap, backpressure and async reset
module tb_bit_seq_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  bit_seq_tx_if #(.WIDTH(8)) ia ();
  bit_seq_tx_if #(.WIDTH(8)) ib ();
  bit_seq_tx_if #(.WIDTH(8)) ic ();
  bit_seq_tx #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b0)) u_a (.clk(clk), .reset(reset), .bus(ia.slave));
  bit_seq_tx #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) u_b (.clk(clk), .reset(reset), .bus(ib.slave));
  bit_seq_tx #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) u_c (.clk(clk), .reset(reset), .bus(ic.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] seq;
    logic [15:0] got;
    int nb;
    ia.din = 8'hB4; ia.din_valid = 1'b1;
    ib.din = 8'h00; ib.din_valid = 1'b0;
    ic.din = 8'h00; ic.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_x", 32'(ia.x), 0);
      chk("rst_xv", 32'(ia.x_valid), 0);
      chk("rst_busy", 32'(ia.busy), 0);
      chk("rst_done", 32'(ia.done), 0);
      chk("rst_ready", 32'(ia.din_ready), 0);
    end
    reset = 1'b1;
    step();
    chk("rel_ready", 32'(ia.din_ready), 1);
    step();
    ia.din_valid = 1'b0;
    seq = 8'b1011_0100;
    for (int i = 1; i <= 8; i++) begin
      chk("lsb_x", 32'(ia.x), 32'(seq[i-1]));
      chk("lsb_xv", 32'(ia.x_valid), 1);
      chk("lsb_done", 32'(ia.done), 32'(i == 8));
      chk("lsb_busy", 32'(ia.busy), 1);
      chk("lsb_ready", 32'(ia.din_ready), 0);
      step();
    end
    for (int i = 9; i <= 10; i++) begin
      chk("gap_xv", 32'(ia.x_valid), 0);
      chk("gap_x", 32'(ia.x), 0);
      chk("gap_busy", 32'(ia.busy), 1);
      chk("gap_ready", 32'(ia.din_ready), 0);
      step();
    end
    chk("idle_ready", 32'(ia.din_ready), 1);
    chk("idle_busy", 32'(ia.busy), 0);
    chk("b_ready", 32'(ib.din_ready), 1);
    ib.din = 8'hB4; ib.din_valid = 1'b1;
    step();
    ib.din_valid = 1'b0;
    seq = 8'b0010_1101;
    for (int i = 1; i <= 8; i++) begin
      chk("msb_x", 32'(ib.x), 32'(seq[i-1]));
      chk("msb_xv", 32'(ib.x_valid), 1);
      chk("msb_done", 32'(ib.done), 32'(i == 8));
      step();
    end
    ia.din = 8'hC3; ia.din_valid = 1'b1;
    chk("bp_ready0", 32'(ia.din_ready), 1);
    step();
    ia.din_valid = 1'b0;
    nb = 0;
    got = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin ia.din = 8'h0F; ia.din_valid = 1'b1; end
      if (c == 12) ia.din_valid = 1'b0;
      if (ia.x_valid) begin got[nb] = ia.x; nb++; end
      if (c >= 3 && c <= 10) chk("bp_hold", 32'(ia.din_ready), 0);
      if (c == 11) begin
        chk("bp_ready", 32'(ia.din_ready), 1);
        chk("bp_xv11", 32'(ia.x_valid), 0);
      end
      if (c == 12) chk("bp_xv12", 32'(ia.x_valid), 1);
      step();
    end
    chk("bp_count", 32'(nb), 16);
    chk("bp_data", 32'(got), 32'h0FC3);
    step();
    step();
    chk("bp_idle", 32'(ia.din_ready), 1);
    ic.din = 8'hFF; ic.din_valid = 1'b1;
    chk("g0_ready", 32'(ic.din_ready), 1);
    step();
    ic.din = 8'h00;
    for (int c = 1; c <= 18; c++) begin
      if (c == 10) ic.din_valid = 1'b0;
      chk("g0_xv", 32'(ic.x_valid), 32'(c != 9 && c <= 17));
      chk("g0_x", 32'(ic.x), 32'(c <= 8));
      chk("g0_done", 32'(ic.done), 32'(c == 8 || c == 17));
      step();
    end
    ia.din = 8'hAA; ia.din_valid = 1'b1;
    step();
    ia.din_valid = 1'b0;
    step();
    step();
    step();
    chk("mr_xv_pre", 32'(ia.x_valid), 1);
    chk("mr_x_pre", 32'(ia.x), 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_x", 32'(ia.x), 0);
    chk("mr_xv", 32'(ia.x_valid), 0);
    chk("mr_busy", 32'(ia.busy), 0);
    step();
    chk("mr_done", 32'(ia.done), 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("mr_ready", 32'(ia.din_ready), 1);
    chk("mr_done2", 32'(ia.done), 0);
    ia.din = 8'h55; ia.din_valid = 1'b1;
    step();
    ia.din_valid = 1'b0;
    seq = 8'b0101_0101;
    for (int i = 1; i <= 8; i++) begin
      chk("mr_word_x", 32'(ia.x), 32'(seq[i-1]));
      chk("mr_word_xv", 32'(ia.x_valid), 1);
      chk("mr_word_done", 32'(ia.done), 32'(i == 8));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bit_seq_tx.md
Name: bit_seq_tx

Overview:
- Serial bit-stream transmitter: accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on `x`, qualified by `x_valid`.
- Produces the serial `x` stream consumed by the team's sequence-detector FSMs. It sits on the transmit side of the same single-bit serial interface.
- Inserts a programmable idle gap between words so the receiver FSM sees defined frame boundaries.

Parameters:
- WIDTH, 8, word length in bits (≥ 2).
- GAP_CYCLES, 2, idle cycles after each word before the next word is accepted (≥ 0).
- MSB_FIRST, 0, bit order: 0 sends din[0] first, 1 sends din[WIDTH-1] first.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- din  in  WIDTH  parallel word to transmit.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  transmitter can accept a word this cycle.
- x  out  1  serial data bit.
- x_valid  out  1  x carries a data bit this cycle.
- busy  out  1  transmitter is in SHIFT or GAP.
- done  out  1  single-cycle pulse coincident with the last data bit of a word.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0, gap counter=0. Outputs: x=0, x_valid=0, busy=0, done=0, din_ready=1 one cycle after reset deasserts. All outputs are driven from registers.
- FSM states: IDLE, SHIFT, GAP. Next-state logic is combinational; state is registered.
- IDLE:
  - din_ready=1, x=0, x_valid=0.
  - On din_valid && din_ready at edge N, capture din and go to SHIFT.
  - First bit appears on x with x_valid=1 in cycle N+1, giving one cycle latency.
- SHIFT:
  - Emits WIDTH consecutive bits, one per cycle, with x_valid=1 throughout. din_ready=0, busy=1.
  - Bit order follows MSB_FIRST. The shift register shifts toward the output end each cycle.
  - Bit counter runs 0..WIDTH-1 and is $clog2(WIDTH) bits wide.
  - done=1 in the cycle carrying bit WIDTH-1 (counter == WIDTH-1).
  - After the last bit: if GAP_CYCLES>0, go to GAP; otherwise go to IDLE.
- GAP:
  - x=0, x_valid=0, busy=1, din_ready=0 for exactly GAP_CYCLES cycles, then IDLE.
  - Gap counter is $clog2(GAP_CYCLES+1) bits wide.
- Back-to-back words with GAP_CYCLES=0:
  - Last bit in cycle K, IDLE in K+1 with din_ready=1.
  - Next word accepted at end of K+1; its first bit appears in K+2.
  - Minimum inter-word spacing is therefore one idle cycle.
- din and din_valid are ignored outside IDLE. A word presented while busy is held by the upstream until din_ready=1; the transmitter never drops an accepted word.
- din_valid may deassert without a handshake; no effect.
- Reset mid-word: the transmission is aborted immediately (asynchronous). x and x_valid go to 0 and the partial word is discarded. No done pulse is generated.
- Illegal or unused state encodings recover to IDLE.

Decomposition:
- Shared package `bit_seq_pkg`:
  - State enum typedef tx_state_t {IDLE, SHIFT, GAP}, 2-bit encoding.
  - Default WIDTH/GAP_CYCLES constants.
  - Serial-interface localparams shared with the detector FSMs (frame/idle-bit value = 0).
- One natural sub-module: `bit_seq_shreg`, a WIDTH-bit loadable shift register with a direction parameter. Controller FSM and counters stay in bit_seq_tx.

Test Plan:
- Reset: hold reset=0 for 3 cycles with din_valid=1 → x=0, x_valid=0, busy=0, done=0 throughout. din_ready=1 on the first cycle after release, and the word is accepted on that edge.
- Single word: WIDTH=8, MSB_FIRST=0, din=8'hB4 accepted at cycle 0.
  - Cycles 1..8 show x = 0,0,1,0,1,1,0,1 with x_valid=1.
  - done=1 only in cycle 8.
  - Cycles 9–10 have x_valid=0 (GAP).
  - din_ready=1 from cycle 11.
- MSB_FIRST=1, din=8'hB4 → x = 1,0,1,1,0,1,0,0 in cycles 1..8.
- Backpressure: present din=8'h0F with din_valid=1 during cycle 3 of an active word.
  - din_ready stays 0 until IDLE.
  - The second word starts exactly one cycle after acceptance.
  - Both words are transmitted intact, with no duplication.
- GAP_CYCLES=0 back-to-back: 8'hFF then 8'h00 →
  - 8 ones, then one x_valid=0 cycle, then 8 zeros.
  - Two done pulses, 9 cycles apart.
- Reset mid-operation: assert reset=0 asynchronously (between edges) during bit 4 of 8'hAA.
  - x and x_valid drop to 0 immediately.
  - No done pulse.
  - After release, din_ready=1 and a fresh word 8'h55 transmits correctly.
